// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg
// Shared types and helpers for the run_monitor execution monitor.
//   rm_state_t : top-level FSM states
//   rm_sel_w() : select/index width for a channel count (clog2, minimum 1)
package run_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    CAPTURE = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } rm_state_t;

  function automatic int rm_sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/halt_detector.sv
// halt_detector
// Tracks the previous program counter and counts consecutive identical
// samples while enabled. Raises a combinational halt pulse on the edge at
// which the repeat count reaches HALT_REPEAT.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   clear          : forget the previous PC and zero the repeat count
//   en             : sample pc on this edge (monitor in RUN)
//   pc             : CPU program counter
//   halt           : this edge completes HALT_REPEAT equal samples
module halt_detector #(
  parameter int PC_W        = 16,
  parameter int HALT_REPEAT = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            halt
);

  localparam int MW = (HALT_REPEAT < 1) ? 1 : $clog2(HALT_REPEAT + 1);

  logic [PC_W-1:0] prev_pc;
  logic            prev_vld;
  logic [MW-1:0]   match;
  logic [MW-1:0]   match_next;

  // The monitor leaves RUN on the halt edge, so match never exceeds HALT_REPEAT.
  always_comb begin
    match_next = '0;
    if (prev_vld && (pc == prev_pc)) match_next = match + 1'b1;
    halt = en && (match_next == MW'(HALT_REPEAT));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
      match    <= '0;
    end else if (clear) begin
      prev_vld <= 1'b0;
      match    <= '0;
    end else if (en) begin
      match    <= match_next;
      prev_pc  <= pc;
      prev_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// run_monitor
// Execution monitor for a CPU under test: counts cycles from start until the
// PC holds still, snapshots NUM_CH watched channels, compares them against
// expected values under a mask and reports the result on registered outputs.
// Optional feature macro: RUN_MONITOR_CHANGE_CNT_EN adds per-channel change
// counters during RUN, read back through rd_changes.
// Ports:
//   clock, reset_n   : clock, asynchronous active-low reset
//   start            : begin a run (honoured in IDLE or DONE)
//   pc               : CPU program counter
//   ch_data          : watched channels, channel i at [i*DATA_W +: DATA_W]
//   exp_data/exp_mask: expected values and per-channel check enable
//   rd_sel/rd_data   : combinational snapshot readout (0 when out of range)
//   rd_changes       : change count of channel rd_sel (feature macro only)
//   cycles           : executed-cycle count of the last run
//   busy/done        : RUN/CAPTURE/CHECK, and DONE
//   pass/timeout     : comparison result, run ended by MAX_CYCLES
//   fail_idx         : first mismatching channel
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 16,
  parameter int NUM_CH      = 4,
  parameter int CYC_W       = 32,
  parameter int HALT_REPEAT = 2,
  parameter int MAX_CYCLES  = 100000
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [PC_W-1:0]               pc,
  input  logic [NUM_CH*DATA_W-1:0]      ch_data,
  input  logic [NUM_CH*DATA_W-1:0]      exp_data,
  input  logic [NUM_CH-1:0]             exp_mask,
  input  logic [rm_sel_w(NUM_CH)-1:0]   rd_sel,
  output logic [DATA_W-1:0]             rd_data,
  output logic [CYC_W-1:0]              cycles,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
`ifdef RUN_MONITOR_CHANGE_CNT_EN
  output logic [DATA_W-1:0]             rd_changes,
`endif
  output logic [rm_sel_w(NUM_CH)-1:0]   fail_idx
);

  localparam int SEL_W = rm_sel_w(NUM_CH);

  rm_state_t         state;
  rm_state_t         state_next;
  logic [CYC_W-1:0]  cnt;
  logic [CYC_W-1:0]  cnt_next;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] snap [NUM_CH];
  logic              run_clear;
  logic              run_en;
  logic              halt;
  logic              hit_max;

  assign run_clear = ((state == IDLE) || (state == DONE)) && start;
  assign run_en    = (state == RUN);
  assign cnt_next  = cnt + 1'b1;
  assign hit_max   = (cnt_next == CYC_W'(MAX_CYCLES));

  halt_detector #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (run_clear),
    .en      (run_en),
    .pc      (pc),
    .halt    (halt)
  );

  // Next-state logic; halt takes priority over timeout on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = RUN;
      RUN: begin
        if (halt)         state_next = CAPTURE;
        else if (hit_max) state_next = DONE;
      end
      CAPTURE:    state_next = CHECK;
      CHECK:      if (idx == SEL_W'(NUM_CH - 1)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      cycles   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      fail_idx <= '0;
      idx      <= '0;
      for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
    end else begin
      state <= state_next;
      // busy/done are flopped from the next state so they are true registers.
      busy  <= (state_next == RUN) || (state_next == CAPTURE) || (state_next == CHECK);
      done  <= (state_next == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt      <= '0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            fail_idx <= '0;
          end
        end
        RUN: begin
          cnt <= cnt_next;
          if (halt) begin
            // The halt samples themselves are not executed cycles.
            cycles <= cnt_next - CYC_W'(HALT_REPEAT);
          end else if (hit_max) begin
            cycles  <= CYC_W'(MAX_CYCLES);
            timeout <= 1'b1;
            pass    <= 1'b0;
          end
        end
        // ---- capture stage: one-edge snapshot of every channel ----
        CAPTURE: begin
          for (int i = 0; i < NUM_CH; i++) snap[i] <= ch_data[i*DATA_W +: DATA_W];
          pass <= 1'b1;
          idx  <= '0;
        end
        // ---- check stage: one channel per edge, first failure sticks ----
        CHECK: begin
          if (exp_mask[idx] && pass &&
              (snap[idx] != exp_data[int'(idx)*DATA_W +: DATA_W])) begin
            pass     <= 1'b0;
            fail_idx <= idx;
          end
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_data = snap[i];
  end

`ifdef RUN_MONITOR_CHANGE_CNT_EN
  logic [DATA_W-1:0] chg_prev [NUM_CH];
  logic [DATA_W-1:0] chg_cnt  [NUM_CH];
  logic              chg_vld;

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // The first RUN sample only seeds chg_prev; changes count from the second.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chg_vld <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        chg_prev[i] <= '0;
        chg_cnt[i]  <= '0;
      end
    end else if (run_clear) begin
      chg_vld <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) chg_cnt[i] <= '0;
    end else if (run_en) begin
      chg_vld <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (chg_vld && (ch_data[i*DATA_W +: DATA_W] != chg_prev[i]))
          chg_cnt[i] <= sat_inc(chg_cnt[i]);
        chg_prev[i] <= ch_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rd_changes = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_changes = chg_cnt[i];
  end
`endif

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor
// Directed-vector bench for run_monitor with NUM_CH=4, HALT_REPEAT=2 and
// MAX_CYCLES=10. Build with RUN_MONITOR_CHANGE_CNT_EN to cover rd_changes.
module tb_run_monitor;

  localparam int DATA_W = 16;
  localparam int PC_W   = 16;
  localparam int NUM_CH = 4;
  localparam int CYC_W  = 32;

  logic                     clock;
  logic                     reset_n;
  logic                     start;
  logic [PC_W-1:0]          pc;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH*DATA_W-1:0] exp_data;
  logic [NUM_CH-1:0]        exp_mask;
  logic [1:0]               rd_sel;
  logic [DATA_W-1:0]        rd_data;
  logic [CYC_W-1:0]         cycles;
  logic                     busy;
  logic                     done;
  logic                     pass;
  logic                     timeout;
  logic [1:0]               fail_idx;
`ifdef RUN_MONITOR_CHANGE_CNT_EN
  logic [DATA_W-1:0]        rd_changes;
`endif

  int checks   = 0;
  int failures = 0;
  int n_edges;
  logic [PC_W-1:0] pc_seq[$];

  run_monitor #(
    .DATA_W      (DATA_W),
    .PC_W        (PC_W),
    .NUM_CH      (NUM_CH),
    .CYC_W       (CYC_W),
    .HALT_REPEAT (2),
    .MAX_CYCLES  (10)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .pc       (pc),
    .ch_data  (ch_data),
    .exp_data (exp_data),
    .exp_mask (exp_mask),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .cycles   (cycles),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .timeout  (timeout),
`ifdef RUN_MONITOR_CHANGE_CNT_EN
    .rd_changes (rd_changes),
`endif
    .fail_idx (fail_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed();
    foreach (pc_seq[i]) begin
      pc = pc_seq[i];
      step();
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic halt_seq();
    pc_seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
  endtask

  task automatic check_snaps(input string tag);
    logic [NUM_CH*DATA_W-1:0] want;
    want = ch_data;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_sel = 2'(i);
      #1;
      check({tag, "_rd", 8'(8'd48 + 8'(i))}, 32'(rd_data), 32'(want[i*DATA_W +: DATA_W]));
    end
    rd_sel = 2'd0;
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    pc       = '0;
    rd_sel   = '0;
    ch_data  = {16'd105, 16'd7, 16'd0, 16'd5};
    exp_data = {16'd105, 16'd7, 16'd0, 16'd5};
    exp_mask = 4'b1111;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_cycles", cycles, 0);
    check("rst_rd", 32'(rd_data), 0);
    reset_n = 1'b1;
    step();

    // Run 1: all channels match.
    start_run();
    check("r1_busy", 32'(busy), 1);
    halt_seq();
    feed();
    check("r1_busy_halt", 32'(busy), 1);
    wait_done(n_edges);
    check("r1_done_lat", 32'(n_edges), 5);
    check("r1_busy_end", 32'(busy), 0);
    check("r1_cycles", cycles, 4);
    check("r1_pass", 32'(pass), 1);
    check("r1_timeout", 32'(timeout), 0);
    check_snaps("r1");

    // Run 2: channels 2 and 3 mismatch; first failure is channel 2.
    ch_data = {16'd9, 16'd8, 16'd0, 16'd5};
    start_run();
    feed();
    wait_done(n_edges);
    check("r2_done_lat", 32'(n_edges), 5);
    check("r2_pass", 32'(pass), 0);
    check("r2_fail_idx", 32'(fail_idx), 2);
    check("r2_cycles", cycles, 4);
    check_snaps("r2");

    // Run 3: same mismatch, masked off.
    exp_mask = 4'b0011;
    start_run();
    feed();
    wait_done(n_edges);
    check("r3_pass", 32'(pass), 1);
    exp_mask = 4'b1111;
    ch_data  = {16'd105, 16'd7, 16'd0, 16'd5};

    // Run 4: timeout at edge S+10, no halt.
    start_run();
    pc_seq = '{};
    for (int i = 0; i < 10; i++) pc_seq.push_back(PC_W'(i + 100));
    feed();
    check("to_done", 32'(done), 1);
    check("to_timeout", 32'(timeout), 1);
    check("to_cycles", cycles, 10);
    check("to_pass", 32'(pass), 0);
    check("to_busy", 32'(busy), 0);

    // Run 5: halt and timeout on the same edge; halt wins. start held high
    // through RUN must be ignored.
    start_run();
    start = 1'b1;
    pc_seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd7, 16'd7};
    feed();
    start = 1'b0;
    check("tie_done", 32'(done), 0);
    check("tie_busy", 32'(busy), 1);
    wait_done(n_edges);
    check("tie_done_lat", 32'(n_edges), 5);
    check("tie_cycles", cycles, 8);
    check("tie_timeout", 32'(timeout), 0);
    check("tie_pass", 32'(pass), 1);

    // Run 6: reset during CHECK aborts to IDLE with all outputs cleared.
    start_run();
    halt_seq();
    feed();
    step();
    step();
    check("ab_in_check", 32'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ab_busy", 32'(busy), 0);
    check("ab_done", 32'(done), 0);
    check("ab_pass", 32'(pass), 0);
    check("ab_timeout", 32'(timeout), 0);
    check("ab_cycles", cycles, 0);
    check("ab_fail_idx", 32'(fail_idx), 0);
    check("ab_rd", 32'(rd_data), 0);
    step();
    reset_n = 1'b1;
    step();
    start_run();
    feed();
    wait_done(n_edges);
    check("ab_rerun_lat", 32'(n_edges), 5);
    check("ab_rerun_pass", 32'(pass), 1);
    check("ab_rerun_cycles", cycles, 4);

`ifdef RUN_MONITOR_CHANGE_CNT_EN
    // Run 7: channel 1 goes 0 -> 3 -> 4 during RUN.
    ch_data  = {16'd105, 16'd7, 16'd0, 16'd5};
    exp_data = {16'd105, 16'd7, 16'd4, 16'd5};
    start_run();
    for (int i = 0; i < 5; i++) begin
      pc = (i < 3) ? PC_W'(i) : PC_W'(2);
      ch_data[DATA_W +: DATA_W] = (i == 0) ? 16'd0 : (i == 1) ? 16'd3 : 16'd4;
      step();
    end
    wait_done(n_edges);
    rd_sel = 2'd1;
    #1;
    check("chg_cnt1", 32'(rd_changes), 2);
    check("chg_rd1", 32'(rd_data), 4);
    rd_sel = 2'd0;
    #1;
    check("chg_cnt0", 32'(rd_changes), 0);
    check("chg_pass", 32'(pass), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Parametrised, synthesizable execution monitor that sits beside `mips16_sc` in special test benches and on the FPGA debug path. It replaces ad-hoc `$monitor` checks. It counts cycles from `start` until the program halts (PC held constant), snapshots `NUM_CH` watched data channels (register-file or data-memory taps) and compares them against expected values under a mask. It then reports pass/fail, the first failing channel and the executed-cycle count through registered outputs and an indexed readout port.

## Interface
- `DATA_W`, 16, width of each watched channel
- `PC_W`, 16, program-counter width
- `NUM_CH`, 4, number of watched channels (1..16)
- `CYC_W`, 32, cycle-counter width
- `HALT_REPEAT`, 2, consecutive equal-PC samples that declare halt (>=1)
- `MAX_CYCLES`, 100000, timeout limit (< 2^CYC_W)

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a run (sampled in IDLE or DONE)
- `pc`  in  PC_W  current CPU program counter
- `ch_data`  in  NUM_CH*DATA_W  watched values, channel i at bits [i*DATA_W +: DATA_W]
- `exp_data`  in  NUM_CH*DATA_W  expected values, same packing
- `exp_mask`  in  NUM_CH  1 = channel checked
- `rd_sel`  in  clog2(NUM_CH) (min 1)  readout channel select
- `rd_data`  out  DATA_W  snapshot of channel `rd_sel`
- `cycles`  out  CYC_W  executed-cycle count of last run
- `busy`  out  1  state is RUN, CAPTURE or CHECK
- `done`  out  1  run finished (state DONE)
- `pass`  out  1  all masked channels matched; valid when `done`
- `timeout`  out  1  run ended by MAX_CYCLES
- `fail_idx`  out  clog2(NUM_CH)  first mismatching channel; valid when `done & ~pass & ~timeout`

## Operation
- States: IDLE -> RUN -> CAPTURE -> CHECK -> DONE. DONE -> RUN on `start`. RUN -> DONE on timeout.
- IDLE/DONE + `start`: clear counter, match count, prev-PC valid flag, `pass`, `timeout` and `fail_idx`. Enter RUN.
- RUN, every edge:
  - `cnt` += 1.
  - If prev valid and `pc == prev_pc`, `match` += 1, else `match` = 0.
  - `prev_pc` <= `pc`; prev valid <= 1.
- Halt: the edge on which `match` reaches HALT_REPEAT. Set `cycles` <= `cnt - HALT_REPEAT` (post-increment `cnt`). Go to CAPTURE.
- Timeout: post-increment `cnt == MAX_CYCLES` without halt. Set `cycles` <= MAX_CYCLES, `timeout` <= 1, `pass` <= 0. Go to DONE; no capture.
- Halt and timeout on the same edge: halt wins.
- CAPTURE, 1 edge: snapshot all `ch_data` into internal registers. Set `pass` <= 1, idx <= 0. Go to CHECK.
- CHECK, 1 channel per edge:
  - If `exp_mask[idx]` and snapshot ≠ `exp_data[idx]` and `pass` is still 1: `pass` <= 0, `fail_idx` <= idx.
  - After idx = NUM_CH-1, go to DONE.
- `exp_data` and `exp_mask` must be stable from CAPTURE until `done`.
- `start` during RUN, CAPTURE or CHECK is ignored.
- `rd_data` = snapshot[`rd_sel`], combinational. `rd_sel` ≥ NUM_CH returns 0.
- Snapshots persist until the next CAPTURE.

## Timing
- Reset: state IDLE. `rd_data`, `cycles`, `busy`, `done`, `pass`, `timeout`, `fail_idx` and all snapshots are 0.
- Reset asserted mid-run aborts immediately to IDLE.
- `start` high at edge S: `busy` = 1 after S. The first counted PC sample is at edge S+1.
- Halt detected at edge E:
  - CAPTURE after E.
  - Snapshot taken at E+1.
  - `done` = 1 after edge E+1+NUM_CH; `busy` falls the same edge.
- Timeout at edge T: `done` = 1 after T.
- All outputs except `rd_data` are registered.

## Configuration
- `RUN_MONITOR_CHANGE_CNT_EN` defined:
  - Adds one saturating `DATA_W`-bit counter per channel, cleared on `start`.
  - Each counter increments on each RUN edge where its `ch_data` differs from the previous RUN sample.
  - New output `rd_changes` (DATA_W) = counter[`rd_sel`]; reset 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

## Structure
- Package `run_monitor_pkg`:
  - State enum `rm_state_t` (IDLE, RUN, CAPTURE, CHECK, DONE).
  - `rm_sel_w(n)` function (clog2 with minimum 1).
- Sub-module `halt_detector`: owns `prev_pc`, prev valid, `match` and the halt pulse; parameters PC_W and HALT_REPEAT.
- Top module holds the FSM, cycle counter, snapshots and compare.

## Test plan
- NUM_CH=4, HALT_REPEAT=2. `start`, then PC 0,1,2,3,3,3; `ch_data`={5,0,7,105}; `exp_data` equal; mask 4'b1111. Required: `cycles`=4, `pass`=1, `done` 5 edges after halt.
- Same run with channel 2 = 8 and channel 3 = 9 vs expected 7 and 105. Required: `pass`=0, `fail_idx`=2.
- Same mismatch, mask 4'b0011. Required: `pass`=1.
- MAX_CYCLES=10, PC incrementing every cycle. Required: `done`=1 and `timeout`=1 after edge S+10, `cycles`=10, `pass`=0.
- `reset_n` low during CHECK. Required: all outputs 0, IDLE; a following run completes normally.
- With `RUN_MONITOR_CHANGE_CNT_EN`: channel 1 toggles 0→3→4 during RUN. Required: `rd_sel`=1 gives `rd_changes`=2 and `rd_data`=4.
